// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART definitions: receiver state encodings, data
//                width and the default bit period shared with the 8N1
//                transmitter.
//  Revision    : 1.0  initial release
// ============================================================================
package uart_pkg;

   localparam int UART_DATA_BITS       = 8;
   // 10 MHz system clock / 115200 baud
   localparam int DEFAULT_CLKS_PER_BIT = 87;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      STOP      = 3'd3,
      CLEANUP   = 3'd4,
      WAIT_HIGH = 3'd5
   } rx_state_t;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_sync.sv
`default_nettype none
// ============================================================================
//  Module      : uart_sync
//  Description : Two-flop synchroniser for an asynchronous input. Both flops
//                take RESET_VALUE on reset so the synchronised output starts
//                at the input's idle level.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_sync
   import uart_pkg::*;
#(
   parameter logic RESET_VALUE = 1'b1
) (
   input  logic i_Clock,
   input  logic i_Reset,
   input  logic i_Async,
   output logic o_Sync
);

   logic r_meta;
   logic r_sync;

   // Two-stage capture of the asynchronous input
   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         r_meta <= RESET_VALUE;
         r_sync <= RESET_VALUE;
      end else begin
         r_meta <= i_Async;
         r_sync <= r_meta;
      end
   end

   assign o_Sync = r_sync;

endmodule : uart_sync
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : 8N1 UART receiver. Synchronises the RX pin, rejects short
//                start-bit glitches, samples each bit at mid-period, flags
//                framing errors and waits out break conditions.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic       i_Clock,
   input  logic       i_Reset,
   input  logic       i_Rx_Serial,
   output logic       o_Rx_DV,
   output logic [7:0] o_Rx_Byte,
   output logic       o_Rx_Active,
   output logic       o_Rx_Frame_Err
);

   // Mid-bit offset measured from the detected start edge
   localparam int HALF_BIT = (CLKS_PER_BIT - 1) / 2;

   localparam logic [7:0] c_HALF_CNT = 8'(HALF_BIT);
   localparam logic [7:0] c_BIT_END  = 8'(CLKS_PER_BIT - 1);
   localparam logic [2:0] c_LAST_IDX = 3'(UART_DATA_BITS - 1);

   logic                      w_rx;

   rx_state_t                 r_state;
   rx_state_t                 w_state;
   logic [7:0]                r_count;
   logic [7:0]                w_count;
   logic [2:0]                r_index;
   logic [2:0]                w_index;
   logic [UART_DATA_BITS-1:0] r_shift;
   logic [UART_DATA_BITS-1:0] w_shift;
   logic                      r_dv;
   logic                      w_dv;
   logic [7:0]                r_byte;
   logic [7:0]                w_byte;
   logic                      r_active;
   logic                      w_active;
   logic                      r_frame_err;
   logic                      w_frame_err;

   uart_sync #(
      .RESET_VALUE (1'b1)
   ) u_rx_sync (
      .i_Clock (i_Clock),
      .i_Reset (i_Reset),
      .i_Async (i_Rx_Serial),
      .o_Sync  (w_rx)
   );

   // State, counters, shift register and output registers
   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         r_state     <= IDLE;
         r_count     <= 8'd0;
         r_index     <= 3'd0;
         r_shift     <= '0;
         r_dv        <= 1'b0;
         r_byte      <= 8'h00;
         r_active    <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_state     <= w_state;
         r_count     <= w_count;
         r_index     <= w_index;
         r_shift     <= w_shift;
         r_dv        <= w_dv;
         r_byte      <= w_byte;
         r_active    <= w_active;
         r_frame_err <= w_frame_err;
      end
   end

   // Next-state and next-output decode; everything holds unless a state changes it
   always_comb begin
      w_state     = r_state;
      w_count     = r_count;
      w_index     = r_index;
      w_shift     = r_shift;
      w_dv        = r_dv;
      w_byte      = r_byte;
      w_active    = r_active;
      w_frame_err = r_frame_err;

      case (r_state)
         IDLE: begin
            w_count = 8'd0;
            w_index = 3'd0;
            if (!w_rx) begin
               w_state = START;
            end
         end

         START: begin
            if (r_count == c_HALF_CNT) begin
               w_count = 8'd0;
               if (!w_rx) begin
                  w_active = 1'b1;
                  w_state  = DATA;
               end else begin
                  // Line went back high before mid-start: treat as noise
                  w_state = IDLE;
               end
            end else begin
               w_count = r_count + 8'd1;
            end
         end

         DATA: begin
            if (r_count == c_BIT_END) begin
               w_count          = 8'd0;
               w_shift[r_index] = w_rx;
               if (r_index == c_LAST_IDX) begin
                  w_index = 3'd0;
                  w_state = STOP;
               end else begin
                  w_index = r_index + 3'd1;
               end
            end else begin
               w_count = r_count + 8'd1;
            end
         end

         STOP: begin
            if (r_count == c_BIT_END) begin
               w_count  = 8'd0;
               w_active = 1'b0;
               if (w_rx) begin
                  w_dv    = 1'b1;
                  w_byte  = r_shift;
                  w_state = CLEANUP;
               end else begin
                  w_frame_err = 1'b1;
                  w_state     = WAIT_HIGH;
               end
            end else begin
               w_count = r_count + 8'd1;
            end
         end

         CLEANUP: begin
            w_dv    = 1'b0;
            w_state = IDLE;
         end

         WAIT_HIGH: begin
            // A held-low line (break) must return high before a new start
            w_frame_err = 1'b0;
            if (w_rx) begin
               w_state = IDLE;
            end
         end

         default: begin
            w_state = IDLE;
         end
      endcase
   end

   assign o_Rx_DV        = r_dv;
   assign o_Rx_Byte      = r_byte;
   assign o_Rx_Active    = r_active;
   assign o_Rx_Frame_Err = r_frame_err;

endmodule : uart_rx
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx
//  Description : Self-checking bench for uart_rx. One instance runs with an
//                8-clock bit period, a second with 16 clocks for the baud
//                tolerance cases. Expected bytes come from a model that
//                samples the ideal line waveform at the receiver's mid-bit
//                instants.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_rx;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx8;
   logic       rx16;

   logic       dv8, act8, fe8;
   logic [7:0] byte8;
   logic       dv16, act16, fe16;
   logic [7:0] byte16;

   int         cyc = 0;
   int         n_pass = 0;
   int         n_total = 0;

   // Per-instance event records captured by the monitor
   int         q8_cyc[$];
   logic [7:0] q8_byte[$];
   int         q16_cyc[$];
   logic [7:0] q16_byte[$];
   int         fe_cnt8 = 0, fe_cyc8 = 0, fe_cnt16 = 0;
   int         rise8 = 0, rise16 = 0;
   logic       act8_prev = 1'b0, act16_prev = 1'b0;
   int         excl = 0;

   uart_rx #(.CLKS_PER_BIT(8)) u_dut8 (
      .i_Clock        (clk),
      .i_Reset        (rst),
      .i_Rx_Serial    (rx8),
      .o_Rx_DV        (dv8),
      .o_Rx_Byte      (byte8),
      .o_Rx_Active    (act8),
      .o_Rx_Frame_Err (fe8)
   );

   uart_rx #(.CLKS_PER_BIT(16)) u_dut16 (
      .i_Clock        (clk),
      .i_Reset        (rst),
      .i_Rx_Serial    (rx16),
      .o_Rx_DV        (dv16),
      .o_Rx_Byte      (byte16),
      .o_Rx_Active    (act16),
      .o_Rx_Frame_Err (fe16)
   );

   always #5 clk = ~clk;

   // Count rising edges so events can be timed against e0
   always @(posedge clk) cyc <= cyc + 1;

   // Record outputs half a cycle after each active edge
   always @(negedge clk) begin
      if (dv8) begin
         q8_cyc.push_back(cyc);
         q8_byte.push_back(byte8);
      end
      if (dv16) begin
         q16_cyc.push_back(cyc);
         q16_byte.push_back(byte16);
      end
      if (fe8) begin
         fe_cnt8++;
         fe_cyc8 = cyc;
      end
      if (fe16) fe_cnt16++;
      if (act8 && !act8_prev) rise8++;
      if (act16 && !act16_prev) rise16++;
      act8_prev  = act8;
      act16_prev = act16;
      if ((dv8 && fe8) || (dv16 && fe16)) excl++;
   end

   // ------------------------------------------------------------------
   // Reference model: the frame is an ideal waveform of 10 bits of p
   // clocks each, idle-high afterwards. A receiver with bit period c
   // looks at the line (c-1)/2 + 1 clocks after e0 plus k whole bit
   // periods (two synchroniser clocks minus the IDLE detect clock).
   // ------------------------------------------------------------------
   function automatic logic line_at(input logic [7:0] d, input logic stop,
                                    input int p, input int t);
      logic [9:0] fr;
      int         idx;
      fr  = {stop, d, 1'b0};
      idx = t / p;
      return (idx < 10) ? fr[idx] : 1'b1;
   endfunction

   function automatic logic [7:0] model_byte(input logic [7:0] d, input int p, input int c);
      logic [7:0] r;
      r = 8'h00;
      for (int k = 1; k <= 8; k++)
         r[k-1] = line_at(d, 1'b1, p, (c - 1) / 2 + 1 + k * c);
      return r;
   endfunction

   function automatic int model_done(input int e0, input int c);
      return e0 + (c - 1) / 2 + 3 + 9 * c;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drive_bit(input bit sel, input logic v, input int n);
      if (sel) rx16 = v;
      else     rx8  = v;
      tick(n);
   endtask

   task automatic send_frame(input bit sel, input logic [7:0] d, input int p,
                             input logic stop, output int e0);
      logic [9:0] fr;
      fr = {stop, d, 1'b0};
      e0 = cyc + 1;
      for (int b = 0; b < 10; b++) drive_bit(sel, fr[b], p);
   endtask

   logic [7:0] last8;
   logic [7:0] exp_b;
   int         e0, e0b, fe_snap, rise_snap;

   initial begin
      rst  = 1'b1;
      rx8  = 1'b1;
      rx16 = 1'b1;
      tick(3);

      // Reset state
      check("reset_dv",     {31'd0, dv8},  32'd0);
      check("reset_byte",   {24'd0, byte8}, 32'h00);
      check("reset_active", {31'd0, act8}, 32'd0);
      check("reset_ferr",   {31'd0, fe8},  32'd0);
      rst = 1'b0;
      tick(5);

      // Single frame 0x37
      rise_snap = rise8;
      send_frame(1'b0, 8'h37, 8, 1'b1, e0);
      tick(4);
      check("f37_count", q8_cyc.size(), 1);
      if (q8_cyc.size() == 1) begin
         check("f37_time", q8_cyc[0], model_done(e0, 8));
         check("f37_byte", {24'd0, q8_byte[0]}, {24'd0, model_byte(8'h37, 8, 8)});
      end
      check("f37_ferr", fe_cnt8, 0);
      check("f37_active_rise", rise8 - rise_snap, 1);
      q8_cyc.delete(); q8_byte.delete();

      // Back-to-back 0xA5 then 0x00, no idle gap
      send_frame(1'b0, 8'hA5, 8, 1'b1, e0);
      send_frame(1'b0, 8'h00, 8, 1'b1, e0b);
      tick(4);
      check("b2b_count", q8_cyc.size(), 2);
      if (q8_cyc.size() == 2) begin
         check("b2b_time0", q8_cyc[0], model_done(e0, 8));
         check("b2b_gap",   q8_cyc[1] - q8_cyc[0], 80);
         check("b2b_byte0", {24'd0, q8_byte[0]}, 32'hA5);
         check("b2b_byte1", {24'd0, q8_byte[1]}, 32'h00);
      end
      q8_cyc.delete(); q8_byte.delete();

      // Random bytes with random idle gaps
      last8 = 8'h00;
      for (int i = 0; i < 5; i++) begin
         exp_b = 8'($urandom);
         if (i == 4 && exp_b == 8'h00) exp_b = 8'h81;
         tick($urandom_range(0, 20));
         send_frame(1'b0, exp_b, 8, 1'b1, e0);
         tick(4);
         check("rnd_count", q8_cyc.size(), 1);
         if (q8_cyc.size() == 1) begin
            check("rnd_time", q8_cyc[0], model_done(e0, 8));
            check("rnd_byte", {24'd0, q8_byte[0]}, {24'd0, model_byte(exp_b, 8, 8)});
         end
         q8_cyc.delete(); q8_byte.delete();
         last8 = exp_b;
      end

      // Three-cycle low glitch on an idle line
      rise_snap = rise8;
      fe_snap   = fe_cnt8;
      drive_bit(1'b0, 1'b0, 3);
      drive_bit(1'b0, 1'b1, 30);
      check("glitch_dv",     q8_cyc.size(), 0);
      check("glitch_active", rise8 - rise_snap, 0);
      check("glitch_byte",   {24'd0, byte8}, {24'd0, last8});
      check("glitch_ferr",   fe_cnt8 - fe_snap, 0);

      // 0xFF with stop bit low, then line held low (break)
      fe_snap = fe_cnt8;
      send_frame(1'b0, 8'hFF, 8, 1'b0, e0);
      drive_bit(1'b0, 1'b0, 40);
      drive_bit(1'b0, 1'b1, 10);
      check("ferr_pulses", fe_cnt8 - fe_snap, 1);
      check("ferr_time",   fe_cyc8, model_done(e0, 8));
      check("ferr_no_dv",  q8_cyc.size(), 0);
      check("ferr_byte",   {24'd0, byte8}, {24'd0, last8});
      send_frame(1'b0, 8'h5A, 8, 1'b1, e0);
      tick(4);
      check("after_ferr_count", q8_cyc.size(), 1);
      if (q8_cyc.size() == 1)
         check("after_ferr_byte", {24'd0, q8_byte[0]}, 32'h5A);
      q8_cyc.delete(); q8_byte.delete();

      // Reset during data bit 4 of 0x3C
      tick(5);
      drive_bit(1'b0, 1'b0, 8);
      exp_b = 8'h3C;
      for (int b = 0; b < 4; b++) drive_bit(1'b0, exp_b[b], 8);
      drive_bit(1'b0, exp_b[4], 3);
      check("pre_reset_active", {31'd0, act8}, 32'd1);
      #2 rst = 1'b1;
      #1;
      check("async_rst_byte",   {24'd0, byte8}, 32'h00);
      check("async_rst_active", {31'd0, act8},  32'd0);
      check("async_rst_dv",     {31'd0, dv8},   32'd0);
      check("async_rst_ferr",   {31'd0, fe8},   32'd0);
      rx8 = 1'b1;
      tick(2);
      rst = 1'b0;
      tick(100);
      check("aborted_no_dv", q8_cyc.size(), 0);
      send_frame(1'b0, 8'hC3, 8, 1'b1, e0);
      tick(4);
      check("post_rst_count", q8_cyc.size(), 1);
      if (q8_cyc.size() == 1)
         check("post_rst_byte", {24'd0, q8_byte[0]}, 32'hC3);
      q8_cyc.delete(); q8_byte.delete();

      // Baud tolerance on the 16-clock receiver: sender at 15 and 17 clocks.
      // The model reports what lands under each mid-bit sample; at 15 clocks
      // the accumulated drift reaches a full half bit by the last data bits.
      send_frame(1'b1, 8'h96, 15, 1'b1, e0);
      tick(8);
      check("tol15_count", q16_cyc.size(), 1);
      if (q16_cyc.size() == 1) begin
         check("tol15_time", q16_cyc[0], model_done(e0, 16));
         check("tol15_byte", {24'd0, q16_byte[0]}, {24'd0, model_byte(8'h96, 15, 16)});
      end
      q16_cyc.delete(); q16_byte.delete();
      tick(10);
      send_frame(1'b1, 8'h96, 17, 1'b1, e0);
      tick(8);
      check("tol17_count", q16_cyc.size(), 1);
      if (q16_cyc.size() == 1) begin
         check("tol17_time", q16_cyc[0], model_done(e0, 16));
         check("tol17_byte", {24'd0, q16_byte[0]}, 32'h96);
      end
      q16_cyc.delete(); q16_byte.delete();
      check("tol_ferr", fe_cnt16, 0);

      check("dv_ferr_exclusive", excl, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_uart_rx
`default_nettype wire
